video_layer_mixer: RTL and testbench

Parametrised successor to the fixed daisy chain of video cores. It composites a background pixel stream with up to NUM_LAYER overlay layers in one pipelined block, using per-layer enable, opaque/50%-blend mode and a global chroma key. All configuration is shadowed and applied only at frame start, so mid-frame changes never tear. It sits between the frame-counter/background cores and the downstream colour-conversion core, and honours the same global `stall`.

---
 rtl/video_layer_mixer.sv | 193 +++++++++++++++++++
 tb/tb_video_layer_mixer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/video_layer_mixer.sv
// video_layer_mixer
// Composites a background pixel stream with NUM_LAYER overlay layers in a
// two-stage pipeline. Layer i can be enabled, drawn opaque or as a 50% blend,
// and dropped where its pixel equals the chroma key. Layer 0 is the bottom
// layer. Configuration is shadowed and reloaded only on a frame-start pixel,
// so changes in the middle of a frame cannot tear the image.
//
// Ports
//   sys_clk, sys_rst        clock; asynchronous active-low reset
//   stall                   global hold; every pipeline register keeps its value
//   source_*                background stream (vld, hc, vc, start, rgb)
//   layer_vld/layer_rgb     per-layer pixels, aligned with source;
//                           layer i sits at [i*3*RGB_W +: 3*RGB_W]
//   cfg_*                   enable/blend/key requests, sampled at frame start
//   sink_*                  composited stream, 2 advances behind source
//   cfg_applied             one-cycle pulse after the shadow config loads

module vlm_lane #(
    parameter int RGB_W = 4
) (
    input  logic               hit_i,
    input  logic               blend_i,
    input  logic [3*RGB_W-1:0] acc_i,
    input  logic [3*RGB_W-1:0] layer_i,
    output logic [3*RGB_W-1:0] acc_o
);
    logic [3*RGB_W-1:0] avg;

    // Per-channel average at RGB_W+1 bits so the carry survives, then floor.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [RGB_W:0] sum;
        assign sum = {1'b0, acc_i[c*RGB_W +: RGB_W]} + {1'b0, layer_i[c*RGB_W +: RGB_W]};
        assign avg[c*RGB_W +: RGB_W] = RGB_W'(sum >> 1);
    end

    always_comb begin
        acc_o = acc_i;
        if (hit_i) acc_o = blend_i ? avg : layer_i;
    end
endmodule

module video_layer_mixer #(
    parameter int NUM_LAYER = 4,
    parameter int RGB_W     = 4,
    parameter int H_SIZE    = 11,
    parameter int V_SIZE    = 11
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         stall,
    input  logic                         source_vld,
    input  logic [H_SIZE-1:0]            source_hc,
    input  logic [V_SIZE-1:0]            source_vc,
    input  logic                         source_start,
    input  logic [3*RGB_W-1:0]           source_rgb,
    input  logic [NUM_LAYER-1:0]         layer_vld,
    input  logic [NUM_LAYER*3*RGB_W-1:0] layer_rgb,
    input  logic [NUM_LAYER-1:0]         cfg_enable,
    input  logic [NUM_LAYER-1:0]         cfg_blend,
    input  logic                         cfg_key_en,
    input  logic [3*RGB_W-1:0]           cfg_key,
    output logic                         sink_vld,
    output logic [H_SIZE-1:0]            sink_hc,
    output logic [V_SIZE-1:0]            sink_vc,
    output logic                         sink_start,
    output logic [3*RGB_W-1:0]           sink_rgb,
    output logic                         cfg_applied
);
    localparam int PIX_W = 3 * RGB_W;

    // Shadow configuration
    logic [NUM_LAYER-1:0] sh_en_q, sh_blend_q;
    logic                 sh_key_en_q;
    logic [PIX_W-1:0]     sh_key_q;
    logic                 cfg_applied_q;

    // Effective configuration for stage 1: on the loading edge the start pixel
    // already sees the new values, so bypass the shadow registers.
    logic                 load;
    logic [NUM_LAYER-1:0] eff_en, eff_blend;
    logic                 eff_key_en;
    logic [PIX_W-1:0]     eff_key;

    assign load       = ~stall & source_vld & source_start;
    assign eff_en     = load ? cfg_enable : sh_en_q;
    assign eff_blend  = load ? cfg_blend  : sh_blend_q;
    assign eff_key_en = load ? cfg_key_en : sh_key_en_q;
    assign eff_key    = load ? cfg_key    : sh_key_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sh_en_q     <= '0;
            sh_blend_q  <= '0;
            sh_key_en_q <= 1'b0;
            sh_key_q    <= '0;
        end else if (load) begin
            sh_en_q     <= cfg_enable;
            sh_blend_q  <= cfg_blend;
            sh_key_en_q <= cfg_key_en;
            sh_key_q    <= cfg_key;
        end
    end

    // Tracks the load edge every cycle; the output is masked during stall.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) cfg_applied_q <= 1'b0;
        else          cfg_applied_q <= load;
    end
    assign cfg_applied = cfg_applied_q & ~stall;

    // Stage 1: hit detection and capture
    logic [NUM_LAYER-1:0]            hit_d;
    logic [NUM_LAYER-1:0][PIX_W-1:0] layer_d;

    for (genvar i = 0; i < NUM_LAYER; i++) begin : g_hit
        logic [PIX_W-1:0] lpix;
        assign lpix       = layer_rgb[i*PIX_W +: PIX_W];
        assign layer_d[i] = lpix;
        assign hit_d[i]   = eff_en[i] & layer_vld[i] & ~(eff_key_en & (lpix == eff_key));
    end

    logic                            s1_vld_q, s1_start_q;
    logic [H_SIZE-1:0]               s1_hc_q;
    logic [V_SIZE-1:0]               s1_vc_q;
    logic [PIX_W-1:0]                s1_bg_q;
    logic [NUM_LAYER-1:0]            s1_hit_q, s1_blend_q;
    logic [NUM_LAYER-1:0][PIX_W-1:0] s1_layer_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            s1_vld_q   <= 1'b0;
            s1_start_q <= 1'b0;
            s1_hc_q    <= '0;
            s1_vc_q    <= '0;
            s1_bg_q    <= '0;
            s1_hit_q   <= '0;
            s1_blend_q <= '0;
            s1_layer_q <= '0;
        end else if (!stall) begin
            s1_vld_q   <= source_vld;
            s1_start_q <= source_start;
            s1_hc_q    <= source_hc;
            s1_vc_q    <= source_vc;
            s1_bg_q    <= source_rgb;
            s1_hit_q   <= hit_d;
            // Blend bits travel with the pixel so a reload between stages
            // cannot change how an in-flight pixel is mixed.
            s1_blend_q <= eff_blend;
            s1_layer_q <= layer_d;
        end
    end

    // Stage 2: bottom-to-top compositing chain
    logic [NUM_LAYER:0][PIX_W-1:0] acc;
    assign acc[0] = s1_bg_q;

    for (genvar i = 0; i < NUM_LAYER; i++) begin : g_lane
        vlm_lane #(.RGB_W(RGB_W)) u_lane (
            .hit_i   (s1_hit_q[i]),
            .blend_i (s1_blend_q[i]),
            .acc_i   (acc[i]),
            .layer_i (s1_layer_q[i]),
            .acc_o   (acc[i+1])
        );
    end

    logic              sink_vld_q, sink_start_q;
    logic [H_SIZE-1:0] sink_hc_q;
    logic [V_SIZE-1:0] sink_vc_q;
    logic [PIX_W-1:0]  sink_rgb_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sink_vld_q   <= 1'b0;
            sink_start_q <= 1'b0;
            sink_hc_q    <= '0;
            sink_vc_q    <= '0;
            sink_rgb_q   <= '0;
        end else if (!stall) begin
            sink_vld_q   <= s1_vld_q;
            sink_start_q <= s1_start_q;
            sink_hc_q    <= s1_hc_q;
            sink_vc_q    <= s1_vc_q;
            sink_rgb_q   <= acc[NUM_LAYER];
        end
    end

    assign sink_vld   = sink_vld_q;
    assign sink_start = sink_start_q;
    assign sink_hc    = sink_hc_q;
    assign sink_vc    = sink_vc_q;
    assign sink_rgb   = sink_rgb_q;
endmodule

// File: tb/tb_video_layer_mixer.sv
module tb_video_layer_mixer;
    localparam int NL = 4;
    localparam int PW = 12;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          stall;
    logic          source_vld;
    logic [10:0]   source_hc;
    logic [10:0]   source_vc;
    logic          source_start;
    logic [PW-1:0] source_rgb;
    logic [NL-1:0] layer_vld;
    logic [NL*PW-1:0] layer_rgb;
    logic [NL-1:0] cfg_enable;
    logic [NL-1:0] cfg_blend;
    logic          cfg_key_en;
    logic [PW-1:0] cfg_key;
    logic          sink_vld;
    logic [10:0]   sink_hc;
    logic [10:0]   sink_vc;
    logic          sink_start;
    logic [PW-1:0] sink_rgb;
    logic          cfg_applied;

    int checks = 0;
    int errors = 0;

    video_layer_mixer dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .stall(stall),
        .source_vld(source_vld), .source_hc(source_hc), .source_vc(source_vc),
        .source_start(source_start), .source_rgb(source_rgb),
        .layer_vld(layer_vld), .layer_rgb(layer_rgb),
        .cfg_enable(cfg_enable), .cfg_blend(cfg_blend),
        .cfg_key_en(cfg_key_en), .cfg_key(cfg_key),
        .sink_vld(sink_vld), .sink_hc(sink_hc), .sink_vc(sink_vc),
        .sink_start(sink_start), .sink_rgb(sink_rgb), .cfg_applied(cfg_applied)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic px(input logic vld, input int hc, input int vc, input logic st,
                      input logic [PW-1:0] bg, input logic [NL-1:0] lv,
                      input logic [PW-1:0] l0, input logic [PW-1:0] l1,
                      input logic [PW-1:0] l2, input logic [PW-1:0] l3);
        source_vld   = vld;
        source_hc    = 11'(hc);
        source_vc    = 11'(vc);
        source_start = st;
        source_rgb   = bg;
        layer_vld    = lv;
        layer_rgb    = {l3, l2, l1, l0};
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; stall = 1'b0;
        cfg_enable = '0; cfg_blend = '0; cfg_key_en = 1'b0; cfg_key = '0;
        px(1'b1, 5, 5, 1'b1, 12'hABC, 4'hF, 12'h111, 12'h222, 12'h333, 12'h444);
        step(); step();
        checks++; if (sink_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", sink_vld); end
        checks++; if (sink_hc !== 11'd0) begin errors++; $display("FAIL reset_hc got %0d exp 0", sink_hc); end
        checks++; if (sink_vc !== 11'd0) begin errors++; $display("FAIL reset_vc got %0d exp 0", sink_vc); end
        checks++; if (sink_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b exp 0", sink_start); end
        checks++; if (sink_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", sink_rgb); end
        checks++; if (cfg_applied !== 1'b0) begin errors++; $display("FAIL reset_applied got %0b exp 0", cfg_applied); end
        px(1'b0, 0, 0, 1'b0, 12'h000, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0);
        sys_rst = 1'b1;
        step();
    endtask

    // Mid-frame config requests before any start pixel must not take effect.
    task automatic test_passthrough();
        cfg_enable = 4'hF;
        for (int i = 0; i < 6; i++) begin
            px(i < 4, i, 3, 1'b0, 12'h123, 4'hF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
            step();
            checks++; if (cfg_applied !== 1'b0) begin errors++; $display("FAIL pass_applied i=%0d got %0b exp 0", i, cfg_applied); end
            if (i >= 1) begin
                checks++; if (sink_vld !== (i - 1 < 4)) begin errors++; $display("FAIL pass_vld i=%0d got %0b", i, sink_vld); end
                if (i - 1 < 4) begin
                    checks++; if (sink_hc !== 11'(i - 1)) begin errors++; $display("FAIL pass_hc got %0d exp %0d", sink_hc, i - 1); end
                    checks++; if (sink_vc !== 11'd3) begin errors++; $display("FAIL pass_vc got %0d exp 3", sink_vc); end
                    checks++; if (sink_rgb !== 12'h123) begin errors++; $display("FAIL pass_rgb got %h exp 123", sink_rgb); end
                end
            end
        end
    endtask

    task automatic test_opaque();
        int pulses = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 0) begin cfg_enable = 4'b0101; cfg_blend = 4'b0000; end
                else        begin cfg_enable = 4'b1111; cfg_blend = 4'b1111; end
                px(1'b1, i, f, i == 0, 12'h000, 4'b1111, 12'hF00, 12'h00F, 12'h0F0, 12'h00F);
                step();
                if (cfg_applied === 1'b1) pulses++;
                checks++; if (cfg_applied !== (i == 0)) begin errors++; $display("FAIL opq_applied f=%0d i=%0d got %0b", f, i, cfg_applied); end
                if (i >= 1) begin
                    checks++; if (sink_rgb !== 12'h0F0) begin errors++; $display("FAIL opq_rgb f=%0d i=%0d got %h exp 0F0", f, i, sink_rgb); end
                    checks++; if (sink_start !== (i == 1)) begin errors++; $display("FAIL opq_start i=%0d got %0b", i, sink_start); end
                end
            end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL opq_pulses got %0d exp 2", pulses); end
    endtask

    task automatic test_blend();
        logic [PW-1:0] exp_rgb;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                if (i == 0) begin
                    cfg_enable = (f == 0) ? 4'b0010 : 4'b0011;
                    cfg_blend  = 4'b0010;
                end else begin
                    cfg_enable = 4'b0000;
                end
                if (f == 0) px(1'b1, i, 10, i == 0, 12'h0F0, 4'hF, 12'h000, 12'hF00, 12'h000, 12'h000);
                else        px(1'b1, i, 11, i == 0, 12'h0F0, 4'hF, 12'hF00, 12'h00F, 12'h000, 12'h000);
                step();
                if (i >= 1) begin
                    exp_rgb = (f == 0) ? 12'h770 : 12'h707;
                    checks++; if (sink_rgb !== exp_rgb) begin errors++; $display("FAIL blend f=%0d i=%0d got %h exp %h", f, i, sink_rgb, exp_rgb); end
                end
            end
        end
    endtask

    task automatic test_key();
        logic [PW-1:0] l3;
        logic [PW-1:0] exp_rgb;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin cfg_enable = 4'b1000; cfg_blend = 4'b0000; cfg_key_en = 1'b1; cfg_key = 12'hF0F; end
            else        cfg_key = 12'hF0E;
            l3 = (i == 1) ? 12'hF0E : 12'hF0F;
            px(1'b1, i, 20, i == 0, 12'h00A, 4'b1000, 12'h0, 12'h0, 12'h0, l3);
            step();
            if (i >= 1) begin
                exp_rgb = (i == 2) ? 12'hF0E : 12'h00A;
                checks++; if (sink_rgb !== exp_rgb) begin errors++; $display("FAIL key i=%0d got %h exp %h", i, sink_rgb, exp_rgb); end
            end
        end
    endtask

    task automatic test_stall();
        px(1'b1, 9,  7, 1'b0, 12'h111, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0); step();
        px(1'b1, 10, 7, 1'b0, 12'h222, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0); step();
        px(1'b1, 11, 7, 1'b0, 12'h333, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0); step();
        // start pixel presented while stalled
        cfg_enable = 4'b0001; cfg_blend = 4'b0000; cfg_key_en = 1'b0; cfg_key = 12'h000;
        px(1'b1, 0, 0, 1'b1, 12'h666, 4'b0001, 12'h444, 12'h0, 12'h0, 12'h0);
        stall = 1'b1;
        #1;
        checks++; if (cfg_applied !== 1'b0) begin errors++; $display("FAIL stall_applied0 got %0b exp 0", cfg_applied); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (sink_hc !== 11'd10 || sink_rgb !== 12'h222 || sink_vld !== 1'b1 || sink_start !== 1'b0)
                begin errors++; $display("FAIL stall_hold k=%0d got hc=%0d rgb=%h vld=%0b st=%0b exp hc=10 rgb=222 vld=1 st=0", k, sink_hc, sink_rgb, sink_vld, sink_start); end
            checks++; if (cfg_applied !== 1'b0) begin errors++; $display("FAIL stall_applied k=%0d got %0b exp 0", k, cfg_applied); end
        end
        stall = 1'b0;
        step();
        checks++; if (cfg_applied !== 1'b1) begin errors++; $display("FAIL stall_load got %0b exp 1", cfg_applied); end
        checks++; if (sink_hc !== 11'd11 || sink_rgb !== 12'h333) begin errors++; $display("FAIL stall_resume got hc=%0d rgb=%h exp hc=11 rgb=333", sink_hc, sink_rgb); end
        cfg_enable = 4'b0000;
        px(1'b1, 1, 0, 1'b0, 12'h555, 4'b0000, 12'h0, 12'h0, 12'h0, 12'h0);
        step();
        checks++; if (sink_start !== 1'b1 || sink_hc !== 11'd0 || sink_rgb !== 12'h444) begin errors++; $display("FAIL stall_startpix got st=%0b hc=%0d rgb=%h exp st=1 hc=0 rgb=444", sink_start, sink_hc, sink_rgb); end
        checks++; if (cfg_applied !== 1'b0) begin errors++; $display("FAIL stall_pulse_len got %0b exp 0", cfg_applied); end
        step();
        checks++; if (sink_hc !== 11'd1 || sink_rgb !== 12'h555 || sink_start !== 1'b0) begin errors++; $display("FAIL stall_next got hc=%0d rgb=%h exp hc=1 rgb=555", sink_hc, sink_rgb); end
    endtask

    task automatic test_reset_mid();
        // shadow currently enables layer 0 opaque
        px(1'b1, 99, 50, 1'b0, 12'h777, 4'b0001, 12'h444, 12'h0, 12'h0, 12'h0); step();
        px(1'b1, 100, 50, 1'b0, 12'h777, 4'b0001, 12'h444, 12'h0, 12'h0, 12'h0); step();
        checks++; if (sink_vld !== 1'b1 || sink_rgb !== 12'h444) begin errors++; $display("FAIL rmid_pre got vld=%0b rgb=%h exp 1/444", sink_vld, sink_rgb); end
        sys_rst = 1'b0;
        #1;
        checks++; if (sink_vld !== 1'b0) begin errors++; $display("FAIL rmid_vld got %0b exp 0", sink_vld); end
        checks++; if (cfg_applied !== 1'b0) begin errors++; $display("FAIL rmid_applied got %0b exp 0", cfg_applied); end
        step();
        sys_rst = 1'b1;
        cfg_enable = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            px(1'b1, 101 + i, 50, 1'b0, 12'h777, 4'b0001, 12'h444, 12'h0, 12'h0, 12'h0);
            step();
            if (i == 0) begin
                checks++; if (sink_vld !== 1'b0) begin errors++; $display("FAIL rmid_flush got %0b exp 0", sink_vld); end
            end else begin
                checks++; if (sink_vld !== 1'b1 || sink_hc !== 11'(100 + i) || sink_rgb !== 12'h777)
                    begin errors++; $display("FAIL rmid_pass i=%0d got vld=%0b hc=%0d rgb=%h exp 1/%0d/777", i, sink_vld, sink_hc, sink_rgb, 100 + i); end
            end
        end
        px(1'b1, 0, 0, 1'b1, 12'h777, 4'b0001, 12'h444, 12'h0, 12'h0, 12'h0); step();
        px(1'b0, 1, 0, 1'b0, 12'h777, 4'b0001, 12'h444, 12'h0, 12'h0, 12'h0); step();
        checks++; if (sink_start !== 1'b1 || sink_rgb !== 12'h444) begin errors++; $display("FAIL rmid_newframe got st=%0b rgb=%h exp 1/444", sink_start, sink_rgb); end
        step();
        checks++; if (sink_vld !== 1'b0) begin errors++; $display("FAIL rmid_bubble got %0b exp 0", sink_vld); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_opaque();
        test_blend();
        test_key();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
